mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter.sv | 108 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one registered output channel.
// The winner's data is registered into y with a valid/ready handshake toward the
// sink; gnt pulses for one cycle on each capture so the producer can advance.
module mux4_rr_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             rdy,
    output logic [WIDTH-1:0] y,
    output logic             vld,
    output logic [1:0]       sel,
    output logic [3:0]       gnt
);

    localparam int unsigned NREQ = 4;

    logic [WIDTH-1:0] y_q,    y_d;
    logic             vld_q,  vld_d;
    logic [1:0]       sel_q,  sel_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       gnt_q,  gnt_d;

    logic             load_c;
    logic [3:0]       elig_c;
    logic [1:0]       win_c;
    logic             found_c;
    logic [1:0]       idx_c;
    logic [WIDTH-1:0] win_data_c;

    // Load when the output slot is empty or being drained this edge; a requester
    // granted last cycle is masked so it cannot be captured twice.
    assign load_c = !vld_q || rdy;
    assign elig_c = req & ~gnt_q;

    // Scan eligible requesters starting just after the last winner, last one checked last.
    always_comb begin
        win_c   = last_q;
        found_c = 1'b0;
        idx_c   = 2'd0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx_c = 2'(last_q + 2'(k));
            if (!found_c && elig_c[idx_c]) begin
                win_c   = idx_c;
                found_c = 1'b1;
            end
        end
    end

    // Data mux driven by the combinational winner.
    always_comb begin
        win_data_c = d0;
        case (win_c)
            2'd0:    win_data_c = d0;
            2'd1:    win_data_c = d1;
            2'd2:    win_data_c = d2;
            default: win_data_c = d3;
        endcase
    end

    // Next-state: capture, go empty, or stall.
    always_comb begin
        y_d    = y_q;
        vld_d  = vld_q;
        sel_d  = sel_q;
        last_d = last_q;
        gnt_d  = 4'b0000;
        if (load_c) begin
            if (found_c) begin
                y_d    = win_data_c;
                sel_d  = win_c;
                vld_d  = 1'b1;
                last_d = win_c;
                gnt_d  = 4'(1) << win_c;
            end else begin
                vld_d = 1'b0;
            end
        end
    end

    // State registers; reset leaves requester 0 with top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            vld_q  <= 1'b0;
            sel_q  <= 2'd0;
            last_q <= 2'd3;
            gnt_q  <= 4'b0000;
        end else begin
            y_q    <= y_d;
            vld_q  <= vld_d;
            sel_q  <= sel_d;
            last_q <= last_d;
            gnt_q  <= gnt_d;
        end
    end

    assign y   = y_q;
    assign vld = vld_q;
    assign sel = sel_q;
    assign gnt = gnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             clk_en;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] d [4];
    logic             rdy;
    logic [WIDTH-1:0] y;
    logic             vld;
    logic [1:0]       sel;
    logic [3:0]       gnt;

    int n_total;
    int n_bad;

    // Reference model state.
    int         m_y;
    bit         m_vld;
    int         m_sel;
    int         m_last;
    bit [3:0]   m_gnt;

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .d0  (d[0]),
        .d1  (d[1]),
        .d2  (d[2]),
        .d3  (d[3]),
        .rdy (rdy),
        .y   (y),
        .vld (vld),
        .sel (sel),
        .gnt (gnt)
    );

    // Clock held low until enabled so reset can be checked with no edge.
    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y    = 0;
        m_vld  = 1'b0;
        m_sel  = 0;
        m_last = 3;
        m_gnt  = 4'b0000;
    endtask

    // One rising edge of the arbitration rules, using inputs as seen at the edge.
    task automatic model_edge();
        bit       load;
        bit [3:0] elig;
        int       w;
        load = !m_vld || rdy;
        elig = req & ~m_gnt;
        if (!load) begin
            m_gnt = 4'b0000;
        end else if (elig == 4'b0000) begin
            m_vld = 1'b0;
            m_gnt = 4'b0000;
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && elig[(m_last + k) % 4]) w = (m_last + k) % 4;
            end
            m_y    = int'(d[w]);
            m_sel  = w;
            m_vld  = 1'b1;
            m_last = w;
            m_gnt  = 4'b0000;
            m_gnt[w] = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".y"},   32'(y),   32'(m_y));
        check({tag, ".vld"}, 32'(vld), 32'(m_vld));
        check({tag, ".sel"}, 32'(sel), 32'(m_sel));
        check({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
        check({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
        if (gnt != 4'b0000) begin
            check({tag, ".gnt_sel"}, 32'(gnt), 32'(4'(1) << sel));
            check({tag, ".gnt_vld"}, 32'(vld), 32'd1);
        end
    endtask

    // Advance one clock, update the model, then sample 1 time unit after the edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // Pulse reset between clock edges; assumes called just after a rising edge.
    task automatic pulse_rst(input string tag);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, ".y0"},   32'(y),   32'd0);
        check({tag, ".vld0"}, 32'(vld), 32'd0);
        check({tag, ".sel0"}, 32'(sel), 32'd0);
        check({tag, ".gnt0"}, 32'(gnt), 32'd0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] yb;
        n_total = 0;
        n_bad   = 0;
        clk_en  = 1'b0;
        rst     = 1'b0;
        req     = 4'b0000;
        rdy     = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = '0;

        // Reset with no clock edge.
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst.y",   32'(y),   32'd0);
        check("rst.vld", 32'(vld), 32'd0);
        check("rst.sel", 32'(sel), 32'd0);
        check("rst.gnt", 32'(gnt), 32'd0);
        clk_en = 1'b1;
        #5 rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle("idle");

        // Single requester: capture every other cycle.
        req  = 4'b0100;
        d[2] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            cycle("single_cap");
            check("single.y",   32'(y),   32'hA5);
            check("single.gnt", 32'(gnt), 32'b0100);
            cycle("single_gap");
            check("single.gap_vld", 32'(vld), 32'd0);
        end

        // Full contention from a fresh reset.
        pulse_rst("rst_fc");
        req = 4'b1111;
        for (int i = 0; i < 4; i++) d[i] = 8'(8'h10 + i);
        for (int i = 0; i < 6; i++) begin
            cycle("full");
            check("full.sel", 32'(sel), 32'(i % 4));
            check("full.y",   32'(y),   32'(8'h10 + (i % 4)));
            check("full.vld", 32'(vld), 32'd1);
        end

        // Backpressure holds the item; release captures the next in rotation.
        pulse_rst("rst_bp");
        req  = 4'b0010;
        d[1] = 8'h3C;
        cycle("bp_cap");
        check("bp.cap_y", 32'(y), 32'h3C);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d[1] = 8'($urandom);
            req  = 4'b0111;
            cycle("bp_hold");
            check("bp.y",   32'(y),   32'h3C);
            check("bp.sel", 32'(sel), 32'd1);
            check("bp.gnt", 32'(gnt), 32'd0);
        end
        rdy = 1'b1;
        cycle("bp_release");
        check("bp.next_sel", 32'(sel), 32'd2);

        // Wrap and skip.
        pulse_rst("rst_wrap");
        req = 4'b1001;
        cycle("wrap0"); check("wrap.s0", 32'(sel), 32'd0);
        cycle("wrap1"); check("wrap.s1", 32'(sel), 32'd3);
        cycle("wrap2"); check("wrap.s2", 32'(sel), 32'd0);
        pulse_rst("rst_skip");
        req = 4'b0100;
        cycle("skip_a"); check("skip.last2", 32'(sel), 32'd2);
        req = 4'b0110;
        cycle("skip_b"); check("skip.sel1", 32'(sel), 32'd1);

        // Async reset mid-stream under backpressure.
        req = 4'b1111;
        cycle("mid_a");
        rdy = 1'b0;
        cycle("mid_b");
        cycle("mid_c");
        pulse_rst("rst_mid");
        req = 4'b1010;
        rdy = 1'b1;
        cycle("mid_r1"); check("mid.sel1", 32'(sel), 32'd1);
        cycle("mid_r2"); check("mid.sel3", 32'(sel), 32'd3);

        // Randomized traffic, including occasional async resets.
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom);
            for (int j = 0; j < 4; j++) d[j] = 8'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            yb  = y;
            if ($urandom_range(0, 99) == 0) begin
                pulse_rst("rnd_rst");
            end else begin
                cycle("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
